// File: rtl/hsst_tx_framer_pkg.sv
// rtl/hsst_tx_framer_pkg.sv - shared frame symbols and FSM encoding for the HSST TX framer
package hsst_tx_framer_pkg;

    localparam logic [7:0]  K_SOF     = 8'hFB;
    localparam logic [7:0]  K_EOF     = 8'hFD;
    localparam logic [7:0]  K_COMMA   = 8'hBC;
    localparam logic [31:0] IDLE_WORD = 32'h50BC_50BC;
    localparam logic [3:0]  IDLE_K    = 4'b0101;
    localparam logic [31:0] EOF_WORD  = {24'h00_0000, K_EOF};
    localparam logic [3:0]  CTRL_K    = 4'b0001;
    localparam logic [3:0]  DATA_K    = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_EOF     = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    function automatic logic [31:0] sof_word(input logic [15:0] len, input logic [7:0] seq);
        return {len, seq, K_SOF};
    endfunction

endpackage

// File: rtl/hsst_tx_csum.sv
// rtl/hsst_tx_csum.sv - 32-bit modulo-2^32 payload checksum accumulator
module hsst_tx_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [31:0] data,
    output logic [31:0] sum
);

    // clr wins over add_en so a frame always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 32'h0;
        end else if (clr) begin
            sum <= 32'h0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/hsst_tx_framer.sv
// rtl/hsst_tx_framer.sv - wraps FIFO payload words into SOF/payload/CSUM/EOF frames on the HSST TX lane
module hsst_tx_framer
    import hsst_tx_framer_pkg::*;
#(
    parameter int unsigned PKT_WORDS = 256,
    parameter int unsigned MIN_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] s_data,
    input  logic        s_vld,
    output logic        s_rdy,
    output logic [31:0] txdata,
    output logic [3:0]  txcharisk,
    output logic        busy,
    output logic [15:0] frm_cnt,
    output logic [15:0] stall_cnt
);

    localparam logic [15:0] LEN      = 16'(PKT_WORDS);
    localparam logic [15:0] LAST_W   = 16'(PKT_WORDS - 1);
    localparam logic [15:0] LAST_GAP = 16'(MIN_GAP - 1);

    state_t      state;
    logic [7:0]  seq;
    logic [15:0] wcnt;
    logic [15:0] gap_cnt;
    logic [31:0] csum;
    logic        pop;

    assign s_rdy = (state == ST_PAYLOAD);
    assign pop   = s_vld & s_rdy;

    hsst_tx_csum u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_SOF),
        .add_en (pop),
        .data   (s_data),
        .sum    (csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            txdata    <= IDLE_WORD;
            txcharisk <= IDLE_K;
            busy      <= 1'b0;
            frm_cnt   <= 16'h0;
            stall_cnt <= 16'h0;
            seq       <= 8'h0;
            wcnt      <= 16'h0;
            gap_cnt   <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    txdata    <= IDLE_WORD;
                    txcharisk <= IDLE_K;
                    if (en && s_vld) begin
                        state <= ST_SOF;
                        busy  <= 1'b1;
                    end
                end
                ST_SOF: begin
                    txdata    <= sof_word(LEN, seq);
                    txcharisk <= CTRL_K;
                    wcnt      <= 16'h0;
                    state     <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (s_vld) begin
                        txdata    <= s_data;
                        txcharisk <= DATA_K;
                        wcnt      <= wcnt + 16'd1;
                        if (wcnt == LAST_W) begin
                            state <= ST_CSUM;
                        end
                    end else begin
                        // starved FIFO: pad with comma fill, the receiver discards it
                        txdata    <= IDLE_WORD;
                        txcharisk <= IDLE_K;
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    txdata    <= csum;
                    txcharisk <= DATA_K;
                    state     <= ST_EOF;
                end
                ST_EOF: begin
                    txdata    <= EOF_WORD;
                    txcharisk <= CTRL_K;
                    frm_cnt   <= frm_cnt + 16'd1;
                    seq       <= seq + 8'd1;
                    gap_cnt   <= 16'h0;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    txdata    <= IDLE_WORD;
                    txcharisk <= IDLE_K;
                    gap_cnt   <= gap_cnt + 16'd1;
                    if (gap_cnt == LAST_GAP) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    txdata    <= IDLE_WORD;
                    txcharisk <= IDLE_K;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsst_tx_framer.sv
// tb/tb_hsst_tx_framer.sv - directed self-checking bench for hsst_tx_framer (PKT_WORDS=4, MIN_GAP=4)
module tb_hsst_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] s_data;
    logic        s_vld;
    logic        s_rdy;
    logic [31:0] txdata;
    logic [3:0]  txcharisk;
    logic        busy;
    logic [15:0] frm_cnt;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hsst_tx_framer #(.PKT_WORDS(4), .MIN_GAP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .s_data    (s_data),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .txdata    (txdata),
        .txcharisk (txcharisk),
        .busy      (busy),
        .frm_cnt   (frm_cnt),
        .stall_cnt (stall_cnt)
    );

    localparam logic [31:0] IDLE_W = 32'h50BC_50BC;

    int checks = 0;
    int passes = 0;

    logic [31:0] fifo[$];
    logic [31:0] log_d[$];
    logic [3:0]  log_k[$];
    int popcnt;
    int hold_after;
    int hold_len;
    int holdcnt;
    int drop_after;

    task automatic drive_inputs();
        if (holdcnt > 0) begin
            s_vld = 1'b0;
            holdcnt--;
        end else begin
            s_vld = (fifo.size() > 0);
        end
        s_data = (fifo.size() > 0) ? fifo[0] : 32'h0;
    endtask

    // one clock: inputs were set at the previous negedge, outputs logged at this negedge
    task automatic cycle();
        bit pop_now;
        pop_now = s_vld && s_rdy && rst_n;
        @(posedge clk);
        @(negedge clk);
        if (pop_now) begin
            fifo.delete(0);
            popcnt++;
            if (popcnt == hold_after) holdcnt = hold_len;
            if (popcnt == drop_after) en = 1'b0;
        end
        log_d.push_back(txdata);
        log_k.push_back(txcharisk);
        drive_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        s_vld = 1'b0;
        s_data = 32'h0;
        fifo.delete();
        popcnt = 0;
        hold_after = -1;
        hold_len = 0;
        holdcnt = 0;
        drop_after = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_d.delete();
        log_k.delete();
    endtask

    function automatic int find_sof(input int from);
        for (int i = from; i < log_d.size(); i++) begin
            if (log_k[i] == 4'b0001 && log_d[i][7:0] == 8'hFB) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        s_vld = 1'b0;
        s_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if ({txdata, txcharisk, s_rdy, busy} !== {IDLE_W, 4'b0101, 1'b0, 1'b0})
                $display("FAIL reset_out cyc%0d: got %h/%b rdy=%b busy=%b want %h/0101 rdy=0 busy=0",
                         i, txdata, txcharisk, s_rdy, busy, IDLE_W);
            else passes++;
        end
        checks++;
        if ({frm_cnt, stall_cnt} !== 32'h0)
            $display("FAIL reset_cnt: got frm=%0d stall=%0d want 0/0", frm_cnt, stall_cnt);
        else passes++;
    endtask

    task automatic test_single_frame();
        logic [31:0] exp_d[11] = '{32'h000400FB, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A,
                                   32'h000000FD, IDLE_W, IDLE_W, IDLE_W, IDLE_W};
        logic [3:0]  exp_k[11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        int s;
        do_reset();
        fifo = '{32'd1, 32'd2, 32'd3, 32'd4};
        en = 1'b1;
        drive_inputs();
        repeat (20) cycle();
        s = find_sof(0);
        checks++;
        if (s !== 1) $display("FAIL frame_sof_pos: got %0d want 1", s);
        else passes++;
        if (s >= 0) begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (s + i >= log_d.size() || log_d[s+i] !== exp_d[i] || log_k[s+i] !== exp_k[i])
                    $display("FAIL frame_word%0d: got %h/%b want %h/%b", i,
                             (s + i < log_d.size()) ? log_d[s+i] : 32'hx,
                             (s + i < log_k.size()) ? log_k[s+i] : 4'hx, exp_d[i], exp_k[i]);
                else passes++;
            end
        end
        checks++;
        if ({frm_cnt, stall_cnt, busy} !== {16'd1, 16'd0, 1'b0})
            $display("FAIL frame_cnt: got frm=%0d stall=%0d busy=%b want 1/0/0", frm_cnt, stall_cnt, busy);
        else passes++;
    endtask

    task automatic test_stall();
        logic [31:0] exp_d[10] = '{32'h000400FB, 32'd1, 32'd2, IDLE_W, IDLE_W, IDLE_W,
                                   32'd3, 32'd4, 32'h0000000A, 32'h000000FD};
        logic [3:0]  exp_k[10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0101,
                                   4'b0000, 4'b0000, 4'b0000, 4'b0001};
        int s;
        do_reset();
        fifo = '{32'd1, 32'd2, 32'd3, 32'd4};
        hold_after = 2;
        hold_len = 3;
        en = 1'b1;
        drive_inputs();
        repeat (25) cycle();
        s = find_sof(0);
        checks++;
        if (s < 0) $display("FAIL stall_sof: got none want SOF");
        else passes++;
        if (s >= 0) begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (s + i >= log_d.size() || log_d[s+i] !== exp_d[i] || log_k[s+i] !== exp_k[i])
                    $display("FAIL stall_word%0d: got %h/%b want %h/%b", i,
                             (s + i < log_d.size()) ? log_d[s+i] : 32'hx,
                             (s + i < log_k.size()) ? log_k[s+i] : 4'hx, exp_d[i], exp_k[i]);
                else passes++;
            end
        end
        checks++;
        if ({stall_cnt, frm_cnt} !== {16'd3, 16'd1})
            $display("FAIL stall_cnt: got stall=%0d frm=%0d want 3/1", stall_cnt, frm_cnt);
        else passes++;
    endtask

    task automatic test_en_drop();
        int s;
        do_reset();
        for (int i = 1; i <= 8; i++) fifo.push_back(32'(i));
        drop_after = 2;
        en = 1'b1;
        drive_inputs();
        repeat (30) cycle();
        s = find_sof(0);
        checks++;
        if (s < 0 || s + 6 >= log_d.size() || log_d[s+5] !== 32'h0000000A || log_d[s+6] !== 32'h000000FD)
            $display("FAIL endrop_frame: sof at %0d, csum/eof not 0000000A/000000FD", s);
        else passes++;
        checks++;
        if (s >= 0 && find_sof(s + 1) >= 0)
            $display("FAIL endrop_second_sof: got SOF at %0d want none", find_sof(s + 1));
        else passes++;
        checks++;
        if ({frm_cnt, busy, s_rdy} !== {16'd1, 1'b0, 1'b0} || fifo.size() != 4)
            $display("FAIL endrop_state: got frm=%0d busy=%b rdy=%b fifo=%0d want 1/0/0/4",
                     frm_cnt, busy, s_rdy, fifo.size());
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        int s;
        int cyc;
        do_reset();
        for (int i = 0; i < 257 * 4; i++) fifo.push_back(32'(i * 3 + 7));
        en = 1'b1;
        drive_inputs();
        cyc = 0;
        while (frm_cnt != 16'd257 && cyc < 4000) begin
            cycle();
            cyc++;
        end
        checks++;
        if (cyc >= 4000) $display("FAIL b2b_timeout: got frm=%0d want 257 within 4000 cycles", frm_cnt);
        else passes++;
        n = 0;
        s = find_sof(0);
        while (s >= 0) begin
            checks++;
            if (log_d[s][15:8] !== 8'(n) || log_d[s][31:16] !== 16'd4)
                $display("FAIL b2b_seq%0d: got %h want len 0004 seq %h", n, log_d[s], 8'(n));
            else passes++;
            n++;
            s = find_sof(s + 1);
        end
        checks++;
        if (n != 257 || frm_cnt !== 16'd257)
            $display("FAIL b2b_count: got sofs=%0d frm=%0d want 257/257", n, frm_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int s;
        int cyc;
        do_reset();
        for (int i = 1; i <= 12; i++) fifo.push_back(32'(i));
        en = 1'b1;
        drive_inputs();
        cyc = 0;
        while (popcnt < 6 && cyc < 60) begin
            cycle();
            cyc++;
        end
        checks++;
        if (popcnt != 6 || frm_cnt !== 16'd1)
            $display("FAIL rstmid_setup: got pops=%0d frm=%0d want 6/1", popcnt, frm_cnt);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txdata, txcharisk, s_rdy, busy, frm_cnt, stall_cnt} !==
            {IDLE_W, 4'b0101, 1'b0, 1'b0, 16'd0, 16'd0})
            $display("FAIL rstmid_async: got %h/%b rdy=%b busy=%b frm=%0d want %h/0101 0 0 0",
                     txdata, txcharisk, s_rdy, busy, frm_cnt, IDLE_W);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        log_d.delete();
        log_k.delete();
        drive_inputs();
        repeat (20) cycle();
        s = find_sof(0);
        checks++;
        if (s < 0 || log_d[s] !== 32'h000400FB)
            $display("FAIL rstmid_sof: got %h want 000400FB", (s >= 0) ? log_d[s] : 32'hx);
        else passes++;
        checks++;
        if (s < 0 || s + 6 >= log_d.size() || log_d[s+1] !== 32'd7 || log_d[s+4] !== 32'd10 ||
            log_d[s+5] !== 32'h00000022 || log_d[s+6] !== 32'h000000FD)
            $display("FAIL rstmid_frame: got first=%h last=%h csum=%h want 7/a/00000022",
                     (s >= 0 && s + 5 < log_d.size()) ? log_d[s+1] : 32'hx,
                     (s >= 0 && s + 5 < log_d.size()) ? log_d[s+4] : 32'hx,
                     (s >= 0 && s + 5 < log_d.size()) ? log_d[s+5] : 32'hx);
        else passes++;
        checks++;
        if (frm_cnt !== 16'd1) $display("FAIL rstmid_frm: got %0d want 1", frm_cnt);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        s_vld = 1'b0;
        s_data = 32'h0;
        popcnt = 0;
        hold_after = -1;
        hold_len = 0;
        holdcnt = 0;
        drop_after = -1;
        test_reset();
        test_single_frame();
        test_stall();
        test_en_drop();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
